// File: rtl/fish_sprite_sched.sv
// fish_sprite_sched: shares one 16x32 12-bit sprite ROM among NUM_FISH fish.
// Pipeline: S1 (hit test, arbitration, ROM address) -> S2 (aligned with
// rom_data) -> registered output (key-colour masking).
module fish_sprite_sched #(
    parameter int unsigned NUM_FISH  = 4,
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SPR_H     = 16,
    parameter logic [11:0] KEY_COLOR = 12'h0F0,
    parameter int unsigned ID_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic [NUM_FISH*10-1:0] fish_x,
    input  logic [NUM_FISH*10-1:0] fish_y,
    input  logic [NUM_FISH-1:0]   fish_en,
    input  logic [NUM_FISH-1:0]   fish_flip,
    input  logic                  upd_req,
    output logic                  upd_ack,
    output logic [3:0]            rom_row,
    output logic [4:0]            rom_col,
    input  logic [11:0]           rom_data,
    output logic                  out_valid,
    output logic [11:0]           out_color,
    output logic                  out_hit,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_overlap
);

    localparam logic [10:0] LP_SPR_W   = 11'(SPR_W);
    localparam logic [10:0] LP_SPR_H   = 11'(SPR_H);
    localparam logic [4:0]  LP_COL_MAX = 5'(SPR_W - 1);

    // Active (displayed) fish state
    logic [NUM_FISH*10-1:0] r_fx;
    logic [NUM_FISH*10-1:0] r_fy;
    logic [NUM_FISH-1:0]    r_en;
    logic [NUM_FISH-1:0]    r_flip;
    logic                   r_ack;

    // S1
    logic                   r_s1_hit;
    logic [ID_W-1:0]        r_s1_id;
    logic                   r_s1_ovl;
    logic                   r_s1_valid;
    logic [3:0]             r_rom_row;
    logic [4:0]             r_rom_col;

    // S2
    logic                   r_s2_hit;
    logic [ID_W-1:0]        r_s2_id;
    logic                   r_s2_ovl;
    logic                   r_s2_valid;

    // Output
    logic                   r_out_valid;
    logic [11:0]            r_out_color;
    logic                   r_out_hit;
    logic [ID_W-1:0]        r_out_id;
    logic                   r_out_ovl;

    // Combinational
    logic [10:0]            w_dx [NUM_FISH];
    logic [10:0]            w_dy [NUM_FISH];
    logic [NUM_FISH-1:0]    w_hit;
    logic                   w_found;
    logic [ID_W-1:0]        w_win_id;
    logic [4:0]             w_win_dx;
    logic [3:0]             w_win_dy;
    logic                   w_win_flip;
    logic [3:0]             w_cnt;
    logic                   w_ovl;
    logic [3:0]             w_row;
    logic [4:0]             w_col;
    logic                   w_load;
    logic                   w_opaque;

    assign w_load = frame_start & upd_req;

    // Per-fish offset with borrow (bit 10) and rectangle hit test
    always_comb begin
        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            w_dx[i]  = {1'b0, pix_x} - {1'b0, r_fx[10*i +: 10]};
            w_dy[i]  = {1'b0, pix_y} - {1'b0, r_fy[10*i +: 10]};
            w_hit[i] = r_en[i] && pix_valid && !w_dx[i][10] && !w_dy[i][10]
                       && (w_dx[i] < LP_SPR_W) && (w_dy[i] < LP_SPR_H);
        end
    end

    // Fixed-priority arbitration (lowest index wins), hit count, ROM address
    always_comb begin
        w_found    = 1'b0;
        w_win_id   = '0;
        w_win_dx   = '0;
        w_win_dy   = '0;
        w_win_flip = 1'b0;
        w_cnt      = '0;
        for (int unsigned i = 0; i < NUM_FISH; i++) begin
            if (w_hit[i]) begin
                w_cnt = w_cnt + 4'd1;
                if (!w_found) begin
                    w_found    = 1'b1;
                    w_win_id   = ID_W'(i);
                    w_win_dx   = w_dx[i][4:0];
                    w_win_dy   = w_dy[i][3:0];
                    w_win_flip = r_flip[i];
                end
            end
        end
        w_ovl = (w_cnt >= 4'd2);
        w_row = '0;
        w_col = '0;
        if (w_found) begin
            w_row = w_win_dy;
            w_col = w_win_flip ? (LP_COL_MAX - w_win_dx) : w_win_dx;
        end
    end

    // Double-buffered position load at frame start, with one-cycle ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fx   <= '0;
            r_fy   <= '0;
            r_en   <= '0;
            r_flip <= '0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= w_load;
            if (w_load) begin
                r_fx   <= fish_x;
                r_fy   <= fish_y;
                r_en   <= fish_en;
                r_flip <= fish_flip;
            end
        end
    end

    // S1: register arbitration result and ROM address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_hit   <= 1'b0;
            r_s1_id    <= '0;
            r_s1_ovl   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_rom_row  <= '0;
            r_rom_col  <= '0;
        end else begin
            r_s1_hit   <= w_found;
            r_s1_id    <= w_win_id;
            r_s1_ovl   <= w_ovl;
            r_s1_valid <= pix_valid;
            r_rom_row  <= w_row;
            r_rom_col  <= w_col;
        end
    end

    // S2: delay pixel attributes to line up with rom_data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_hit   <= 1'b0;
            r_s2_id    <= '0;
            r_s2_ovl   <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_hit   <= r_s1_hit;
            r_s2_id    <= r_s1_id;
            r_s2_ovl   <= r_s1_ovl;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign w_opaque = r_s2_hit && (rom_data != KEY_COLOR);

    // Output stage: mask the key colour and register the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_color <= '0;
            r_out_hit   <= 1'b0;
            r_out_id    <= '0;
            r_out_ovl   <= 1'b0;
        end else begin
            r_out_valid <= r_s2_valid;
            r_out_color <= w_opaque ? rom_data : '0;
            r_out_hit   <= w_opaque;
            r_out_id    <= r_s2_hit ? r_s2_id : '0;
            r_out_ovl   <= r_s2_ovl;
        end
    end

    assign upd_ack     = r_ack;
    assign rom_row     = r_rom_row;
    assign rom_col     = r_rom_col;
    assign out_valid   = r_out_valid;
    assign out_color   = r_out_color;
    assign out_hit     = r_out_hit;
    assign out_id      = r_out_id;
    assign out_overlap = r_out_ovl;

endmodule

// File: tb/tb_fish_sprite_sched.sv
// Scoreboard bench for fish_sprite_sched with a synchronous ROM model.
module tb_fish_sprite_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [39:0] fish_x;
    logic [39:0] fish_y;
    logic [3:0]  fish_en;
    logic [3:0]  fish_flip;
    logic        upd_req;
    logic        upd_ack;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_data = '0;
    logic        out_valid;
    logic [11:0] out_color;
    logic        out_hit;
    logic [1:0]  out_id;
    logic        out_overlap;

    typedef struct {
        logic        hit;
        logic [11:0] color;
        logic [1:0]  id;
        logic        ovl;
        logic [3:0]  row;
        logic [4:0]  col;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    fish_sprite_sched #(
        .NUM_FISH (4),
        .SPR_W    (32),
        .SPR_H    (16),
        .KEY_COLOR(12'h0F0),
        .ID_W     (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .fish_x     (fish_x),
        .fish_y     (fish_y),
        .fish_en    (fish_en),
        .fish_flip  (fish_flip),
        .upd_req    (upd_req),
        .upd_ack    (upd_ack),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_color  (out_color),
        .out_hit    (out_hit),
        .out_id     (out_id),
        .out_overlap(out_overlap)
    );

    always #5 clk = ~clk;

    // ROM contents: white at (3,7), key colour at (0,0), else {3'b101,row,col}
    function automatic logic [11:0] rom_fn(input logic [3:0] r, input logic [4:0] c);
        if (r == 4'd3 && c == 5'd7) return 12'hFFF;
        if (r == 4'd0 && c == 5'd0) return 12'h0F0;
        return {3'b101, r, c};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_row, rom_col);

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: ROM address history lets each result be matched to its address
    logic [3:0] row_d1, row_d2;
    logic [4:0] col_d1, col_d2;

    always @(negedge clk) begin
        if (!reset_n) begin
            row_d1 = '0; row_d2 = '0; col_d1 = '0; col_d2 = '0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    chk("out_hit",     out_hit,     m_e.hit);
                    chk("out_color",   out_color,   m_e.color);
                    chk("out_id",      out_id,      m_e.id);
                    chk("out_overlap", out_overlap, m_e.ovl);
                    chk("rom_row",     row_d2,      m_e.row);
                    chk("rom_col",     col_d2,      m_e.col);
                end
            end else begin
                chk("idle_out_hit",   out_hit,   0);
                chk("idle_out_color", out_color, 0);
            end
            row_d2 = row_d1; row_d1 = rom_row;
            col_d2 = col_d1; col_d1 = rom_col;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fish(input int i, input int x, input int y,
                            input logic en, input logic flip);
        fish_x[i*10 +: 10] = 10'(x);
        fish_y[i*10 +: 10] = 10'(y);
        fish_en[i]         = en;
        fish_flip[i]       = flip;
    endtask

    task automatic load();
        upd_req     = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        upd_req     = 1'b0;
        chk("upd_ack_pulse", upd_ack, 1);
        tick();
        chk("upd_ack_clear", upd_ack, 0);
    endtask

    task automatic send(input int x, input int y, input logic hit, input int color,
                        input int id, input logic ovl, input int row, input int col);
        exp_t e;
        e.hit = hit; e.color = 12'(color); e.id = 2'(id);
        e.ovl = ovl; e.row = 4'(row); e.col = 5'(col);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        sb.push_back(e);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic send_invalid(input int x, input int y);
        pix_valid = 1'b0;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        tick();
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_upd_ack"},     upd_ack,     0);
        chk({pfx, "_rom_row"},     rom_row,     0);
        chk({pfx, "_rom_col"},     rom_col,     0);
        chk({pfx, "_out_valid"},   out_valid,   0);
        chk({pfx, "_out_color"},   out_color,   0);
        chk({pfx, "_out_hit"},     out_hit,     0);
        chk({pfx, "_out_id"},      out_id,      0);
        chk({pfx, "_out_overlap"}, out_overlap, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; upd_req = 1'b0;
        pix_x = '0; pix_y = '0; fish_x = '0; fish_y = '0; fish_en = '0; fish_flip = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(); tick();

        // Fish 0 at (100,50), unflipped
        set_fish(0, 100, 50, 1'b1, 1'b0);
        load();
        send(107, 53, 1, 'hFFF, 0, 0, 3, 7);
        send(100, 50, 0, 0, 0, 0, 0, 0);        // key colour: masked, id still 0
        send(99, 50, 0, 0, 0, 0, 0, 0);         // dx borrow
        send(132, 50, 0, 0, 0, 0, 0, 0);        // dx == SPR_W
        send(100, 66, 0, 0, 0, 0, 0, 0);        // dy == SPR_H
        send(131, 65, 1, 'hBFF, 0, 0, 15, 31);  // far corner
        send_invalid(107, 53);
        send_invalid(107, 53);

        // Horizontal mirror
        set_fish(0, 100, 50, 1'b1, 1'b1);
        load();
        send(107, 53, 1, 'hA78, 0, 0, 3, 24);
        send(100, 50, 1, 'hA1F, 0, 0, 0, 31);

        // Overlap: fish1 and fish2 share a spot, fish3 past the screen edge
        set_fish(0, 100, 50, 1'b0, 1'b0);
        set_fish(1, 200, 100, 1'b1, 1'b0);
        set_fish(2, 200, 100, 1'b1, 1'b1);
        set_fish(3, 1000, 470, 1'b1, 1'b0);
        load();
        send(205, 105, 1, 'hAA5, 1, 1, 5, 5);
        send(200, 100, 0, 0, 1, 1, 0, 0);       // key colour under an overlap
        send(107, 53, 0, 0, 0, 0, 0, 0);        // fish0 disabled
        send(639, 479, 0, 0, 0, 0, 0, 0);       // fish3 off-screen
        send(215, 105, 1, 'hAAF, 1, 1, 5, 15);

        // Mid-frame update request waits for frame_start
        set_fish(0, 300, 300, 1'b1, 1'b0);
        set_fish(1, 0, 0, 1'b0, 1'b0);
        set_fish(2, 0, 0, 1'b0, 1'b0);
        set_fish(3, 0, 0, 1'b0, 1'b0);
        upd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(205, 105, 1, 'hAA5, 1, 1, 5, 5);
            chk("upd_ack_wait", upd_ack, 0);
        end
        frame_start = 1'b1;
        send(205, 105, 1, 'hAA5, 1, 1, 5, 5);   // same-cycle pixel uses old positions
        frame_start = 1'b0;
        upd_req     = 1'b0;
        chk("upd_ack_mid_pulse", upd_ack, 1);
        send(305, 305, 1, 'hAA5, 0, 0, 5, 5);
        chk("upd_ack_once", upd_ack, 0);
        send(205, 105, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stream
        set_fish(0, 100, 50, 1'b1, 1'b0);
        load();
        send(107, 53, 1, 'hFFF, 0, 0, 3, 7);
        send(107, 53, 1, 'hFFF, 0, 0, 3, 7);
        pix_valid = 1'b1;
        reset_n   = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        pix_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        send(107, 53, 0, 0, 0, 0, 0, 0);        // all fish disabled after reset

        repeat (6) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
